// File: rtl/regression_pkg.sv
// Shared types and defaults for the least-squares regression datapath.
package regression_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClr     = 3'd1,
    StArm     = 3'd2,
    StStream  = 3'd3,
    StWaitAcc = 3'd4,
    StInv     = 3'd5,
    StDone    = 3'd6
  } state_e;

  localparam int unsigned DefNSamples   = 256;
  localparam int unsigned DefAddrW      = 8;
  localparam int unsigned DefXW         = 12;
  localparam int unsigned DefYW         = 16;
  localparam int unsigned DefInvTimeout = 64;

endpackage

// File: rtl/regression_watchdog.sv
// Cycle watchdog: cleared by load, counts while run is high, flags expiry after Limit cycles.
module regression_watchdog #(
  parameter int unsigned Limit = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q;

  // Expiry is seen in the Limit-th cycle of run, so the owner leaves after exactly Limit cycles.
  assign expired = run && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/regression_ctrl.sv
// Job sequencer for the regression datapath: clear, stream N samples, invert, hand off.
// Define REGRESSION_CTRL_TIMEOUT_EN to add the WAIT_ACC/INV watchdog and res_err.
module regression_ctrl
  import regression_pkg::*;
#(
  parameter int unsigned N_SAMPLES   = DefNSamples,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned X_W         = DefXW,
  parameter int unsigned Y_W         = DefYW,
  parameter int unsigned INV_TIMEOUT = DefInvTimeout
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [X_W-1:0]    mem_x,
  input  logic [Y_W-1:0]    mem_y,
  output logic [X_W-1:0]    acc_x,
  output logic [Y_W-1:0]    acc_y,
  output logic              acc_start,
  output logic              acc_clr_n,
  input  logic              xtx_valid,
  input  logic              xty_valid,
  output logic              inv_start,
  output logic              inv_clr_n,
  input  logic              inv_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_err,
  output logic              busy
);

  if ((64'd1 << ADDR_W) < 64'(N_SAMPLES)) begin : g_addr_w_check
    $error("ADDR_W too narrow for N_SAMPLES");
  end
  if (INV_TIMEOUT == 0) begin : g_timeout_check
    $error("INV_TIMEOUT must be non-zero");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              xtx_seen_q, xtx_seen_d, xty_seen_q, xty_seen_d;
  logic              job_ready_d, busy_d, mem_rd_d, acc_start_d, acc_clr_n_d;
  logic              inv_start_d, inv_clr_n_d, res_valid_d;
  logic              last_addr, acc_done, timeout;

  assign acc_x     = mem_x;
  assign acc_y     = mem_y;
  assign last_addr = (addr_q == ADDR_W'(N_SAMPLES - 1));
  // A valid arriving in the same cycle as the other flag completes the pair without delay.
  assign acc_done  = (xtx_seen_q | xtx_valid) & (xty_seen_q | xty_valid);

`ifdef REGRESSION_CTRL_TIMEOUT_EN
  logic wd_load, wd_run, res_err_q, res_err_d;

  assign wd_run  = (state_q == StWaitAcc) || (state_q == StInv);
  assign wd_load = (state_d != state_q) && ((state_d == StWaitAcc) || (state_d == StInv));

  regression_watchdog #(
    .Limit(INV_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_load),
    .run    (wd_run),
    .expired(timeout)
  );

  // DONE reached from WAIT_ACC is always a timeout; from INV only when inv_valid is absent.
  always_comb begin
    res_err_d = 1'b0;
    if (state_d == StDone) begin
      if (state_q == StDone) begin
        res_err_d = res_err_q;
      end else if (state_q == StInv) begin
        res_err_d = !inv_valid;
      end else begin
        res_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err_q <= 1'b0;
    end else begin
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (job_valid) state_d = StClr;
      StClr:     state_d = StArm;
      StArm:     state_d = StStream;
      StStream:  if (last_addr) state_d = StWaitAcc;
      StWaitAcc: begin
        if (acc_done) begin
          state_d = StInv;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StInv:     if (inv_valid || timeout) state_d = StDone;
      StDone:    if (res_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    xtx_seen_d = xtx_seen_q;
    xty_seen_d = xty_seen_q;
    if (state_q == StWaitAcc) begin
      xtx_seen_d = xtx_seen_q | xtx_valid;
      xty_seen_d = xty_seen_q | xty_valid;
    end
    if (state_d != StWaitAcc) begin
      xtx_seen_d = 1'b0;
      xty_seen_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_comb begin
    job_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    acc_clr_n_d = (state_d != StClr);
    inv_clr_n_d = (state_d != StClr);
    acc_start_d = (state_d == StArm);
    mem_rd_d    = (state_d inside {StArm, StStream});
    inv_start_d = (state_d == StInv);
    res_valid_d = (state_d == StDone);
    addr_d      = (state_d == StStream) ? addr_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      xtx_seen_q <= 1'b0;
      xty_seen_q <= 1'b0;
      job_ready  <= 1'b1;
      busy       <= 1'b0;
      acc_clr_n  <= 1'b0;
      inv_clr_n  <= 1'b0;
      acc_start  <= 1'b0;
      mem_rd     <= 1'b0;
      inv_start  <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      xtx_seen_q <= xtx_seen_d;
      xty_seen_q <= xty_seen_d;
      job_ready  <= job_ready_d;
      busy       <= busy_d;
      acc_clr_n  <= acc_clr_n_d;
      inv_clr_n  <= inv_clr_n_d;
      acc_start  <= acc_start_d;
      mem_rd     <= mem_rd_d;
      inv_start  <= inv_start_d;
      res_valid  <= res_valid_d;
    end
  end

  assign mem_addr = addr_q;

endmodule

// File: tb/tb_regression_ctrl.sv
// Directed bench for regression_ctrl with RAM, accumulator and inverter models.
module tb_regression_ctrl;

  localparam int unsigned N  = 256;
  localparam int unsigned AW = 8;
  localparam int unsigned XW = 12;
  localparam int unsigned YW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic          job_ready, mem_rd, acc_start, acc_clr_n, inv_start, inv_clr_n;
  logic          res_valid, res_err, busy, inv_valid;
  logic [AW-1:0] mem_addr;
  logic [XW-1:0] mem_x = '0, acc_x;
  logic [YW-1:0] mem_y = '0, acc_y;
  logic          xtx_valid = 1'b0, xty_valid = 1'b0;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  regression_ctrl #(
    .N_SAMPLES(N), .ADDR_W(AW), .X_W(XW), .Y_W(YW), .INV_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
    .acc_x(acc_x), .acc_y(acc_y), .acc_start(acc_start), .acc_clr_n(acc_clr_n),
    .xtx_valid(xtx_valid), .xty_valid(xty_valid), .inv_start(inv_start),
    .inv_clr_n(inv_clr_n), .inv_valid(inv_valid), .res_valid(res_valid),
    .res_ready(res_ready), .res_err(res_err), .busy(busy)
  );

  // Sample RAM with one-cycle read latency.
  logic [XW-1:0] ram_x [N];
  logic [YW-1:0] ram_y [N];
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_x <= ram_x[mem_addr];
      mem_y <= ram_y[mem_addr];
    end
  end

  // Accumulator pair model: adds every cycle after acc_start, then pulses its valids.
  bit     acc_run = 1'b0;
  bit     spur_en = 1'b0;
  int     acc_n = 0, tx_cd = 0, ty_cd = 0;
  int     xtx_dly = 2, xty_dly = 2;
  longint sum_x = 0, sum_xx = 0, sum_xy = 0;
  always @(posedge clk) begin
    if (!acc_clr_n) begin
      acc_run <= 1'b0; acc_n <= 0; tx_cd <= 0; ty_cd <= 0;
      sum_x <= 0; sum_xx <= 0; sum_xy <= 0;
      xtx_valid <= 1'b0; xty_valid <= 1'b0;
    end else begin
      xtx_valid <= 1'b0;
      xty_valid <= 1'b0;
      if (acc_run) begin
        sum_x  <= sum_x + longint'(acc_x);
        sum_xx <= sum_xx + longint'(acc_x) * longint'(acc_x);
        sum_xy <= sum_xy + longint'(acc_x) * longint'(acc_y);
        acc_n  <= acc_n + 1;
        if (acc_n == N - 1) begin
          acc_run <= 1'b0; tx_cd <= xtx_dly; ty_cd <= xty_dly;
        end
        if (spur_en && acc_n == 50) begin
          xtx_valid <= 1'b1; xty_valid <= 1'b1;
        end
      end
      if (acc_start) acc_run <= 1'b1;
      if (tx_cd != 0) begin
        tx_cd <= tx_cd - 1;
        if (tx_cd == 1) xtx_valid <= 1'b1;
      end
      if (ty_cd != 0) begin
        ty_cd <= ty_cd - 1;
        if (ty_cd == 1) xty_valid <= 1'b1;
      end
    end
  end

  // Inverter model: done after 4 cycles of start, unless stuck.
  bit inv_stuck = 1'b0;
  int inv_cnt = 0;
  always @(posedge clk) begin
    if (!inv_clr_n) inv_cnt <= 0;
    else if (inv_start && inv_cnt < 4) inv_cnt <= inv_cnt + 1;
  end
  assign inv_valid = !inv_stuck && (inv_cnt == 4);

  // Monitor; per-job counters restart whenever the clear is low.
  int unsigned rd_count, exp_addr, addr_err, start_count, clr_cyc, start_cyc;
  int unsigned rv_cycles, inv_cyc, xtx_cyc;
  logic        inv_prev = 1'b0;
  always @(negedge clk) begin
    if (!acc_clr_n) begin
      rd_count = 0; exp_addr = 0; addr_err = 0; start_count = 0;
      clr_cyc = cyc; rv_cycles = 0; inv_cyc = 0; xtx_cyc = 0;
    end else begin
      if (mem_rd) begin
        if (int'(mem_addr) != exp_addr) addr_err++;
        exp_addr++;
        rd_count++;
      end
      if (acc_start) begin
        start_count++;
        start_cyc = cyc;
      end
      if (res_valid) rv_cycles++;
      if (inv_start && !inv_prev) inv_cyc = cyc;
      if (xtx_valid) xtx_cyc = cyc;
    end
    inv_prev = inv_start;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_job();
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, res_valid, 1'b1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // Order: job_ready busy mem_rd acc_start acc_clr_n inv_start inv_clr_n res_valid res_err
  function automatic logic [8:0] outs();
    return {job_ready, busy, mem_rd, acc_start, acc_clr_n, inv_start, inv_clr_n, res_valid,
            res_err};
  endfunction

  initial begin
    int hold_ok;
    int n;
    int unsigned rise;
    for (int i = 0; i < N; i++) begin
      ram_x[i] = 12'd16;
      ram_y[i] = 16'd2;
    end
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs(), 9'b1_0000_0000);
    check_eq("reset_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", outs(), 9'b1_0001_0100);

    // Job 1: x = 1.0, y = 2 everywhere.
    start_job();
    wait_res("job1_res_valid");
    check_eq("job1_rd_count", rd_count, N);
    check_eq("job1_addr_order", addr_err, 0);
    check_eq("job1_start_count", start_count, 1);
    check_eq("job1_start_after_clr", start_cyc - clr_cyc, 1);
    check_eq("job1_xtx_ans0", acc_n, N);
    check_eq("job1_sum_xx", sum_xx, 65536);
    check_eq("job1_sum_xy", sum_xy, 8192);
    check_eq("job1_res_err", res_err, 1'b0);

    // Hold DONE for 10 cycles, reloading RAM for job 2 meanwhile.
    for (int i = 0; i < N; i++) begin
      ram_x[i] = XW'(i);
      ram_y[i] = 16'd3;
    end
    hold_ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid && !job_ready && busy) hold_ok++;
      @(negedge clk);
    end
    check_eq("hold_done", hold_ok, 10);
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("handshake_idle", {res_valid, job_ready, busy}, 3'b010);

    // Job 2 back to back, res_ready already high, stray job_valid mid-stream.
    start_job();
    repeat (60) @(negedge clk);
    job_valid = 1'b1;
    repeat (5) @(negedge clk);
    job_valid = 1'b0;
    wait_res("job2_res_valid");
    @(negedge clk);
    check_eq("job2_one_cycle_done", {res_valid, job_ready}, 2'b01);
    check_eq("job2_rv_cycles", rv_cycles, 1);
    check_eq("job2_rd_count", rd_count, N);
    check_eq("job2_count", acc_n, N);
    check_eq("job2_sum_x", sum_x, 32640);
    check_eq("job2_sum_xx", sum_xx, 5559680);
    check_eq("job2_sum_xy", sum_xy, 97920);
    repeat (5) @(negedge clk);
    check_eq("job_not_queued", busy, 1'b0);
    res_ready = 1'b0;

    // Job 3: xty 3 cycles ahead of xtx, plus stray valids during streaming.
    xty_dly = 1; xtx_dly = 4; spur_en = 1'b1;
    start_job();
    wait_res("job3_res_valid");
    check_eq("inv_after_xtx", inv_cyc - xtx_cyc, 1);
    handshake();
    xty_dly = 2; xtx_dly = 2; spur_en = 1'b0;

    // Job 4: reset around address 100, then a clean restart.
    start_job();
    n = 0;
    while (mem_addr != AW'(100) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_addr100", mem_addr, 100);
    rst_n = 1'b0;
    #1;
    check_eq("midjob_reset_outs", outs(), 9'b1_0000_0000);
    check_eq("midjob_reset_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job();
    wait_res("job5_res_valid");
    check_eq("job5_rd_count", rd_count, N);
    check_eq("job5_addr_order", addr_err, 0);
    check_eq("job5_count", acc_n, N);
    handshake();

`ifdef REGRESSION_CTRL_TIMEOUT_EN
    inv_stuck = 1'b1;
    start_job();
    wait_res("to_res_valid");
    rise = cyc;
    check_eq("to_delay", rise - inv_cyc, TO);
    check_eq("to_res_err", res_err, 1'b1);
    handshake();
    check_eq("to_err_clear", {res_valid, res_err}, 2'b00);
    inv_stuck = 1'b0;
`else
    rise = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
